// File: rtl/image_readback_tx.sv
// Image readback: packs 1-bit RAM contents into bytes (LSB first) and feeds them to uart_tx.
// Define IMAGE_READBACK_CHECKSUM_EN to append an XOR checksum byte after the image.
module image_readback_tx #(
  parameter int unsigned NUM_BITS = 784,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_q,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_rdy
);

  localparam int unsigned NumBytes = NUM_BITS / 8;
  localparam logic [ADDR_W-1:0] LastByte = ADDR_W'(NumBytes - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StSend, StHold, StWait, StFin} state_e;

  state_e            state_q, state_d;
  logic [3:0]        bit_q, bit_d;
  logic [ADDR_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [6:0]        shift_q, shift_d;
  logic [7:0]        tx_data_q, tx_data_d;
`ifdef IMAGE_READBACK_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic              csum_phase_q, csum_phase_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      bit_q      <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      tx_data_q  <= '0;
`ifdef IMAGE_READBACK_CHECKSUM_EN
      csum_q       <= '0;
      csum_phase_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      tx_data_q  <= tx_data_d;
`ifdef IMAGE_READBACK_CHECKSUM_EN
      csum_q       <= csum_d;
      csum_phase_q <= csum_phase_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    tx_data_d  = tx_data_q;
`ifdef IMAGE_READBACK_CHECKSUM_EN
    csum_d       = csum_q;
    csum_phase_d = csum_phase_q;
`endif
    busy     = (state_q != StIdle);
    done     = 1'b0;
    tx_start = 1'b0;
    ram_addr = '0;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StFetch;
          bit_d      = '0;
          byte_cnt_d = '0;
`ifdef IMAGE_READBACK_CHECKSUM_EN
          csum_d       = '0;
          csum_phase_d = 1'b0;
`endif
        end
      end
      StFetch: begin
        // Cycle k issues address k; RAM data for address k-1 arrives in the same cycle.
        if (bit_q < 4'd8) begin
          ram_addr = {byte_cnt_q[ADDR_W-4:0], bit_q[2:0]};
        end
        if (bit_q == 4'd8) begin
          tx_data_d = {ram_q, shift_q};
`ifdef IMAGE_READBACK_CHECKSUM_EN
          csum_d = csum_q ^ {ram_q, shift_q};
`endif
          bit_d   = '0;
          state_d = StSend;
        end else begin
          if (bit_q != 4'd0) begin
            shift_d[3'(bit_q - 4'd1)] = ram_q;
          end
          bit_d = bit_q + 4'd1;
        end
      end
      StSend: begin
        if (tx_rdy) begin
          tx_start = 1'b1;
          state_d  = StHold;
        end
      end
      StHold: begin
        state_d = StWait;
      end
      StWait: begin
        if (tx_rdy) begin
`ifdef IMAGE_READBACK_CHECKSUM_EN
          if (csum_phase_q) begin
            state_d = StFin;
          end else if (byte_cnt_q == LastByte) begin
            tx_data_d    = csum_q;
            csum_phase_d = 1'b1;
            state_d      = StSend;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            state_d    = StFetch;
          end
`else
          if (byte_cnt_q == LastByte) begin
            state_d = StFin;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            state_d    = StFetch;
          end
`endif
        end
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign tx_data = tx_data_q;

endmodule

// File: tb/tb_image_readback_tx.sv
// Bench for image_readback_tx: RAM and uart_tx models, byte-level reference, directed scenarios.
module tb_image_readback_tx;
  localparam int NB = 784 / 8;
`ifdef IMAGE_READBACK_CHECKSUM_EN
  localparam int NTX = NB + 1;
`else
  localparam int NTX = NB;
`endif

  logic       clk = 1'b0;
  logic       rst, start, busy, done, ram_q, tx_start, tx_rdy;
  logic [9:0] ram_addr;
  logic [7:0] tx_data;

  image_readback_tx #(.NUM_BITS(784), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .ram_addr(ram_addr), .ram_q(ram_q), .tx_start(tx_start), .tx_data(tx_data),
    .tx_rdy(tx_rdy)
  );

  always #10 clk = ~clk;

  bit         ram [0:783];
  int         errors = 0;
  int         checks = 0;
  int         uart_cnt = 0;
  bit         force_low = 1'b0;
  int         tx_idx = 0;
  int         done_cnt = 0;
  logic [7:0] sent[$];
  logic [7:0] last_tx = 8'h00;

  // One-cycle-latency RAM and a uart_tx that stays busy 10 cycles after each start.
  always @(posedge clk) ram_q <= ram[ram_addr];
  always @(posedge clk) begin
    if (rst) uart_cnt <= 0;
    else if (tx_start) uart_cnt <= 10;
    else if (uart_cnt > 0) uart_cnt <= uart_cnt - 1;
  end
  assign tx_rdy = (uart_cnt == 0) && !force_low;

  function automatic logic [7:0] exp_byte(int j);
    logic [7:0] b = 8'h00;
    if (j < NB) begin
      for (int k = 0; k < 8; k++) b[k] = ram[8 * j + k];
    end else begin
      for (int i = 0; i < NB; i++) b = b ^ exp_byte(i);
    end
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (tx_start === 1'b1) begin
        check("tx_count_bound", tx_idx < NTX, 1);
        check("tx_byte", tx_data, exp_byte(tx_idx));
        sent.push_back(tx_data);
        last_tx = tx_data;
        tx_idx++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        check("done_after_last", tx_idx, NTX);
      end
      if (busy === 1'b0) check("addr_idle", ram_addr, 0);
      else if (uart_cnt != 0) check("tx_data_stable", tx_data, last_tx);
    end
  end

  task automatic clear_run();
    tx_idx = 0;
    done_cnt = 0;
    sent.delete();
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 8000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 8000) check("done_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_idx(input int idx);
    int n = 0;
    while (tx_idx < idx && n < 8000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 8000) check("idx_timeout", 0, 1);
  endtask

  task automatic check_run_end(input string tag);
    check({tag, "_tx_count"}, tx_idx, NTX);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_busy_low"}, busy, 0);
  endtask

  initial begin
    int n;
    int hold_err;
    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 784; i++) ram[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_ram_addr", ram_addr, 0);

    // All-zero image
    clear_run();
    pulse_start();
    @(negedge clk);
    check("start_busy", busy, 1);
    check("start_addr", ram_addr, 0);
    n = 1;
    while (tx_start !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("first_tx_latency", n, 10);
    wait_done();
    check_run_end("zero");
    check("zero_byte0", sent[0], 8'h00);
    check("zero_last", sent[NB-1], 8'h00);

    // RAM[i] = i[0]
    for (int i = 0; i < 784; i++) ram[i] = i[0];
    check("model_aa", exp_byte(0), 8'hAA);
    clear_run();
    pulse_start();
    wait_done();
    check_run_end("aa");
    check("aa_byte0", sent[0], 8'hAA);
    check("aa_last", sent[NB-1], 8'hAA);
`ifdef IMAGE_READBACK_CHECKSUM_EN
    check("aa_csum", sent[NB], 8'h00);
`endif

    // Only the two end bits set
    for (int i = 0; i < 784; i++) ram[i] = 1'b0;
    ram[0] = 1'b1;
    ram[783] = 1'b1;
    check("model_end0", exp_byte(0), 8'h01);
    check("model_end97", exp_byte(97), 8'h80);
    clear_run();
    pulse_start();
    wait_done();
    check_run_end("ends");
    check("ends_byte0", sent[0], 8'h01);
    check("ends_byte1", sent[1], 8'h00);
    check("ends_byte97", sent[97], 8'h80);
`ifdef IMAGE_READBACK_CHECKSUM_EN
    check("ends_csum", sent[NB], 8'h81);
`endif

    // tx_rdy held low while the first byte waits in SEND
    clear_run();
    @(posedge clk); #1 force_low = 1'b1;
    pulse_start();
    repeat (15) @(negedge clk);
    hold_err = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tx_start !== 1'b0 || tx_data !== 8'h01) hold_err++;
    end
    check("hold_no_start", hold_err, 0);
    check("hold_data", tx_data, 8'h01);
    @(posedge clk); #1 force_low = 1'b0;
    @(negedge clk);
    check("rdy_rise_start", tx_start, 1);
    wait_done();
    check_run_end("hold");

    // Second start during byte 40 is ignored
    for (int i = 0; i < 784; i++) ram[i] = i[0];
    clear_run();
    pulse_start();
    wait_idx(41);
    pulse_start();
    wait_done();
    check_run_end("restart");

    // Reset during byte 50, then a fresh readback
    clear_run();
    pulse_start();
    wait_idx(51);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tx_start", tx_start, 0);
    check("mid_rst_tx_data", tx_data, 8'h00);
    check("mid_rst_addr", ram_addr, 0);
    check("mid_rst_done", done, 0);
    repeat (300) @(negedge clk);
    check("mid_rst_no_done", done_cnt, 0);
    clear_run();
    pulse_start();
    @(negedge clk);
    check("rerun_busy", busy, 1);
    check("rerun_addr", ram_addr, 0);
    wait_done();
    check_run_end("rerun");
    check("rerun_byte0", sent[0], 8'hAA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
